// File: rtl/sram_controller_pkg.sv
// Shared constants and state encoding for the SRAM controller.
// Holds the data-region base, default wait count, SRAM widths and FSM states.
package sram_controller_pkg;

    localparam int DATA_BASE       = 1024;
    localparam int WAIT_CYCLES_DEF = 3;
    localparam int SRAM_AW         = 18;
    localparam int SRAM_DW         = 16;
    localparam int WORD_AW         = SRAM_AW - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOW  = 2'b01,
        ST_HIGH = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/sram_controller.sv
// 32-bit word read/write responder driving a 16-bit async SRAM.
// Each word occupies two SRAM half-words, low half first.
// Ports:
//   clk, rst (sync, active-high)
//   write_en, read_en, address[31:0], write_data[31:0]  request side
//   read_data[31:0], ready                              response side
//   SRAM_DQ[15:0] (inout), SRAM_ADDR[17:0], SRAM_WE_N, SRAM_OE_N,
//   SRAM_CE_N, SRAM_UB_N, SRAM_LB_N                      SRAM pins
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 write_en,
    input  logic                 read_en,
    input  logic [31:0]          address,
    input  logic [31:0]          write_data,
    output logic [31:0]          read_data,
    output logic                 ready,
    inout  wire  [SRAM_DW-1:0]   SRAM_DQ,
    output logic [SRAM_AW-1:0]   SRAM_ADDR,
    output logic                 SRAM_WE_N,
    output logic                 SRAM_OE_N,
    output logic                 SRAM_CE_N,
    output logic                 SRAM_UB_N,
    output logic                 SRAM_LB_N
);

    localparam int CW = ($clog2(WAIT_CYCLES) < 2) ? 2 : $clog2(WAIT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_nxt;
    logic                 r_wr;
    logic [WORD_AW-1:0]   r_addr;
    logic [31:0]          r_wdata;
    logic [SRAM_DW-1:0]   r_rlo;
    logic [31:0]          r_rdata;

    logic                 w_start;
    logic                 w_last;
    logic                 w_addr_lsb;
    logic                 w_we_n;
    logic                 w_oe_n;
    logic                 w_dq_oe;
    logic [SRAM_DW-1:0]   w_dq_out;
    logic [WORD_AW-1:0]   w_addr_w;

    assign w_addr_w = WORD_AW'((address - 32'(DATA_BASE)) >> 2);
    assign w_last   = (r_cnt == LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_start     = 1'b0;
        w_addr_lsb  = 1'b0;
        w_we_n      = 1'b1;
        w_oe_n      = 1'b1;
        w_dq_oe     = 1'b0;
        w_dq_out    = r_wdata[15:0];
        unique case (r_state)
            ST_IDLE: begin
                if (write_en || read_en) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_LOW;
                end
            end
            ST_LOW: begin
                w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
                if (w_last) w_state_nxt = ST_HIGH;
                // WE_N rises in the last cycle so addr/data hold across it
                w_we_n  = ~r_wr | w_last;
                w_oe_n  = r_wr;
                w_dq_oe = r_wr;
            end
            ST_HIGH: begin
                w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
                if (w_last) w_state_nxt = ST_DONE;
                w_addr_lsb = 1'b1;
                w_we_n     = ~r_wr | w_last;
                w_oe_n     = r_wr;
                w_dq_oe    = r_wr;
                w_dq_out   = r_wdata[31:16];
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rlo   <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_start) begin
                r_wr    <= write_en;
                r_addr  <= w_addr_w;
                r_wdata <= write_data;
            end
            // Low half is staged so read_data only changes entering DONE
            if (!r_wr && r_state == ST_LOW && w_last)
                r_rlo <= SRAM_DQ;
            if (!r_wr && r_state == ST_HIGH && w_last)
                r_rdata <= {SRAM_DQ, r_rlo};
        end
    end

    assign ready = ((r_state == ST_IDLE) && !(read_en || write_en))
                 || (r_state == ST_DONE);

    assign read_data = r_rdata;
    assign SRAM_ADDR = {r_addr, w_addr_lsb};
    assign SRAM_WE_N = w_we_n;
    assign SRAM_OE_N = w_oe_n;
    assign SRAM_DQ   = w_dq_oe ? w_dq_out : {SRAM_DW{1'bz}};
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule
